// File: rtl/bec_dec_pipe_pkg.sv
// Shared constants and helpers for the excess-1-to-binary decoder pipeline.
package bec_dec_pipe_pkg;

  localparam int BEC_W_MIN = 4;
  localparam int BEC_W_MAX = 32;

  function automatic bit w_legal(input int w);
    return (w >= BEC_W_MIN) && (w <= BEC_W_MAX) && ((w % 2) == 0);
  endfunction

  function automatic int half_w(input int w);
    return w / 2;
  endfunction

endpackage

// File: rtl/bec_dec_n.sv
// Combinational N-bit decrement cell: d = a - 1, bo set when a is zero (borrow out).
module bec_dec_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] d,
  output logic         bo
);

  // Bit i flips exactly when every lower bit is zero.
  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign d[0] = ~a[0];
    end else begin : g_up
      assign d[i] = a[i] ^ ~(|a[i-1:0]);
    end
  end

  assign bo = ~(|a);

endmodule

// File: rtl/bec_dec_pipe.sv
// Two-stage excess-1-to-binary decoder (y = x - 1) with carry-select split and valid/ready flow.
module bec_dec_pipe
  import bec_dec_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         uf
);

  localparam int H = half_w(W);

  if (!w_legal(W)) begin : g_bad_w
    $error("bec_dec_pipe: W must be even and within 4..32");
  end

  logic         s1_valid;
  logic [H-1:0] s1_lo;
  logic [H-1:0] s1_hi;
  logic         s1_b;
  logic         s2_valid;
  logic         s1_en;
  logic         s2_en;
  logic [H-1:0] lo_dec_c;
  logic         lo_bo;
  logic [H-1:0] hi_dec_c;
  logic         hi_bo;
  logic         in_xfer;

  assign s2_en    = ~s2_valid | out_ready;
  assign s1_en    = ~s1_valid | s2_en;
  assign in_ready = s1_en;
  assign in_xfer  = in_valid & s1_en;

  bec_dec_n #(.N(H)) u_lo_dec (
    .a  (x[H-1:0]),
    .d  (lo_dec_c),
    .bo (lo_bo)
  );

  bec_dec_n #(.N(H)) u_hi_dec (
    .a  (s1_hi),
    .d  (hi_dec_c),
    .bo (hi_bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_hi    <= '0;
      s1_b     <= 1'b0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_lo <= lo_dec_c;
        s1_hi <= x[W-1:H];
        s1_b  <= lo_bo;
      end
    end
  end

  // Upper half picks between x_hi and x_hi-1 using the stage-1 borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      y        <= '0;
      uf       <= 1'b0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      y        <= {(s1_b ? hi_dec_c : s1_hi), s1_lo};
      uf       <= s1_b & hi_bo;
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_bec_dec_pipe.sv
// Directed and randomized self-checking bench for bec_dec_pipe at W=8.
module tb_bec_dec_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       uf;

  int n_tests = 0;
  int n_fail  = 0;

  bec_dec_pipe #(.W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .uf        (uf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single word through an otherwise idle pipe, checking the 2-cycle latency.
  task automatic send_one(input logic [7:0] xv, input logic [7:0] ey, input logic euf);
    in_valid = 1'b1;
    x        = xv;
    #1;
    chk("one_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("one_lat1_valid", 32'(out_valid), 32'd0);
    step();
    chk("one_valid", 32'(out_valid), 32'd1);
    chk("one_y", 32'(y), 32'(ey));
    chk("one_uf", 32'(uf), 32'(euf));
    step();
    chk("one_drain", 32'(out_valid), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] ex;
  logic [7:0] next_x;
  int         sent;
  int         got;
  logic       acc;
  logic       oxf;
  logic       held;
  logic [7:0] held_y;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_uf", 32'(uf), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    send_one(8'h01, 8'h00, 1'b0);
    send_one(8'h80, 8'h7F, 1'b0);
    send_one(8'hFF, 8'hFE, 1'b0);
    send_one(8'h10, 8'h0F, 1'b0);
    send_one(8'h00, 8'hFF, 1'b1);

    // Throughput: 16 back-to-back words, outputs expected on consecutive cycles.
    for (int i = 0; i < 19; i++) begin
      in_valid = (i < 16);
      x        = 8'(i + 1);
      #1;
      if (i < 16) chk("tp_in_ready", 32'(in_ready), 32'd1);
      chk("tp_out_valid", 32'(out_valid), 32'((i >= 2) && (i < 18)));
      if ((i >= 2) && (i < 18)) chk("tp_y", 32'(y), 32'(i - 2));
      step();
    end
    in_valid = 1'b0;

    // Backpressure: two words fill the pipe, then in_ready must drop.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    x         = 8'h05;
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    step();
    x = 8'h09;
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    x = 8'h33;
    #1;
    chk("bp_full_rdy", 32'(in_ready), 32'd0);
    chk("bp_full_valid", 32'(out_valid), 32'd1);
    chk("bp_full_y", 32'(y), 32'h04);
    step();
    chk("bp_hold_rdy", 32'(in_ready), 32'd0);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_y", 32'(y), 32'h04);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_y", 32'(y), 32'h08);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Reset with two words in flight.
    in_valid = 1'b1;
    x        = 8'h40;
    step();
    x = 8'h41;
    step();
    in_valid = 1'b0;
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("mr_post_valid", 32'(out_valid), 32'd0);
    chk("mr_post_y", 32'(y), 32'd0);
    send_one(8'h21, 8'h20, 1'b0);

    // All 256 codes under random in_valid/out_ready, in-order scoreboard.
    sent = 0;
    got  = 0;
    held = 1'b0;
    held_y = 8'h00;
    for (int cyc = 0; cyc < 4000 && got < 256; cyc++) begin
      next_x    = 8'(sent);
      in_valid  = (sent < 256) && ($urandom_range(0, 3) != 0);
      x         = next_x;
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (held) begin
        chk("ex_hold_valid", 32'(out_valid), 32'd1);
        chk("ex_hold_y", 32'(y), 32'(held_y));
      end
      acc  = in_valid & in_ready;
      oxf  = out_valid & out_ready;
      held = out_valid & ~out_ready;
      held_y = y;
      if (oxf) begin
        if (q.size() == 0) begin
          chk("ex_spurious_out", 32'd1, 32'd0);
        end else begin
          ex = q.pop_front();
          chk("ex_y", 32'(y), 32'(8'(ex - 8'd1)));
          chk("ex_uf", 32'(uf), 32'(ex == 8'h00));
        end
        got++;
      end
      if (acc) begin
        q.push_back(next_x);
        sent++;
      end
      step();
    end
    in_valid = 1'b0;
    chk("ex_all_received", 32'(got), 32'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bec_dec_pipe.md
Name: bec_dec_pipe

Overview:
- Pipelined excess-1-to-binary decoder: y = x - 1. It is the inverse of the binary-to-excess-1 converters used in the carry-select adder datapath.
- Decrement is split carry-select style:
  - the lower half borrow chain is resolved in stage 1;
  - the upper half is selected between x_hi and x_hi-1 in stage 2.
- Valid/ready handshake on both sides; full throughput of 1 word per cycle; latency 2 cycles.
- Sits between excess-1-coded result registers and binary consumers.

Parameters:
W, 8, data width in bits; legal range 4..32; must be even.
H, W/2, split point; lower half is bits [H-1:0]; derived, not overridable.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  x is valid this cycle
in_ready  output  1  block accepts x this cycle
x  input  W  excess-1 coded operand
out_valid  output  1  y/uf are valid
out_ready  input  1  consumer accepts y this cycle
y  output  W  binary result, x-1 modulo 2^W
uf  output  1  underflow: x was 0, so y = all ones

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid flags clear. out_valid=0, y=0, uf=0, in_ready=1 on the first cycle after release. Pipeline data registers are also cleared to 0.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_valid, y and uf hold stable while out_valid=1 and out_ready=0.
- Stage advance:
  - s2_en = ~s2_valid | out_ready.
  - s1_en = ~s1_valid | s2_en.
  - in_ready = s1_en, which is purely combinational from register state and out_ready.
  - No path from in_valid to in_ready.
- Stage 1, on an input transfer:
  - register lo_dec = x[H-1:0]-1 and x_hi = x[W-1:H];
  - register b = (x[H-1:0]==0), the borrow out of the lower half;
  - s1_valid <= 1.
  - If s1_en is high and there is no input transfer: s1_valid <= 0.
- Stage 2, when s2_en:
  - y <= {b ? x_hi-1 : x_hi, lo_dec};
  - uf <= b & (x_hi==0);
  - s2_valid <= s1_valid.
  - Stage 2 holds when s2_en=0.
- Arithmetic:
  - Decrement cell per bit: d[0] = ~a[0]; d[i] = a[i] ^ ~|a[i-1:0] (borrow = all lower bits zero).
  - No `-` operator is required; the cell is written bitwise.
- Latency: an input transfer in cycle n produces out_valid in cycle n+2 if out_ready stays high.
- Throughput: back-to-back inputs with out_ready=1 produce back-to-back outputs with no bubbles.
- Backpressure: with out_ready=0 the pipe fills 2 deep, then in_ready drops in the same cycle. in_ready rises in the same cycle out_ready rises.
- Boundaries:
  - x=0 gives y=all ones, uf=1.
  - x=2^W-1 gives y=2^W-2, uf=0.
  - x=2^H (lower half zero) is the borrow-crossing case; the upper half must decrement.
- Reset mid-operation: in-flight words are discarded with no partial output. out_valid drops asynchronously with rst_n.

Decomposition:
- Shared package:
  - width check constant (W even, 4..32);
  - a function or constant for H = W/2.
- Sub-module: bec_dec_n (parameter N), the combinational N-bit decrement cell with borrow-out. It is instantiated for the lower half in stage 1 and the upper half in stage 2. It mirrors the existing bec_N naming.

Test Plan:
- Basic decode, W=8: x=8'h01 -> y=8'h00, uf=0; x=8'h80 -> 8'h7F; x=8'hFF -> 8'hFE. Each output appears 2 cycles after acceptance.
- Borrow across halves and underflow: x=8'h10 -> y=8'h0F, uf=0; x=8'h00 -> y=8'hFF, uf=1.
- Throughput: stream x=1..16 with out_ready=1 -> outputs 0..15 on 16 consecutive cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0 after 2 accepted words (8'h05, 8'h09) -> in_ready=0 on the next cycle and y holds 8'h04. Raise out_ready -> 8'h04 then 8'h08 with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 2 words in flight -> out_valid=0 immediately. After release, the first new input x=8'h21 -> y=8'h20 with no stale output.
- Exhaustive: all 256 x values with random in_valid/out_ready -> in-order scoreboard matches (x-1) mod 256, and uf=1 only for x=0.
